fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_queue.sv | 88 ++++++++
 tb/tb_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch queue
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fq_entry_t;
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear, used for the instruction queue and the request tags
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic             do_push, do_pop;
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction
    assign empty_o = count_o == '0;
    assign full_o  = count_o == CW'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    // a pop frees the slot, so a full FIFO still takes a simultaneous push
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem[rd_q];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_o <= '0;
        end else if (clr_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_q <= next_ptr(wr_q);
            if (do_pop) rd_q <= next_ptr(rd_q);
            count_o <= count_o + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem[wr_q] <= din_i;
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order I-cache fetcher feeding a decode queue, with redirect and stale-response drain
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          FQ_DEPTH  = 4,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redir_i,
    input  logic [31:0] redir_pc_i,
    output logic        ic_req_valid_o,
    input  logic        ic_req_ready_i,
    output logic [31:0] ic_req_addr_o,
    input  logic        ic_rsp_valid_i,
    input  logic [31:0] ic_rsp_data_i,
    input  logic        ic_rsp_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_err_o
);
    localparam int QW = $clog2(FQ_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    fetch_state_e  state_q;
    logic [31:0]   pc_q, pc_n, tag_pc;
    logic [OW-1:0] outst_cnt, drop_q, drop_n;
    logic [QW-1:0] q_count;
    logic          q_full, q_empty, t_full, t_empty;
    logic          req_fire, rsp_ok, keep;
    fq_entry_t     head, wr_entry;
    assign ic_req_valid_o = rst_ni && !redir_i && !t_full && !q_full
                            && (int'(q_count) + int'(outst_cnt) < FQ_DEPTH);
    assign ic_req_addr_o  = pc_q;
    assign req_fire       = ic_req_valid_o && ic_req_ready_i;
    // a response with nothing outstanding is ignored
    assign rsp_ok         = ic_rsp_valid_i && !t_empty;
    assign keep           = rsp_ok && !redir_i && state_q == RUN;
    assign wr_entry       = '{pc: tag_pc, inst: ic_rsp_data_i, err: ic_rsp_err_i};
    assign inst_valid_o   = !q_empty;
    assign inst_o         = inst_valid_o ? head.inst : '0;
    assign inst_pc_o      = inst_valid_o ? head.pc : '0;
    assign inst_err_o     = inst_valid_o && head.err;
    fetch_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (redir_i),
        .push_i  (keep),
        .din_i   (wr_entry),
        .pop_i   (inst_valid_o && inst_ready_i),
        .dout_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );
    fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_tags (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (1'b0),
        .push_i  (req_fire),
        .din_i   (pc_q),
        .pop_i   (rsp_ok),
        .dout_o  (tag_pc),
        .full_o  (t_full),
        .empty_o (t_empty),
        .count_o (outst_cnt)
    );
    always_comb begin
        pc_n   = redir_i ? {redir_pc_i[31:2], 2'b00} : req_fire ? pc_q + 32'd4 : pc_q;
        // everything in flight at a redirect is stale, except a response consumed this cycle
        drop_n = redir_i ? outst_cnt - OW'(rsp_ok)
               : (rsp_ok && state_q == DRAIN) ? drop_q - OW'(1) : drop_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= RESET_PC;
            drop_q  <= '0;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_n;
            drop_q  <= drop_n;
            state_q <= drop_n != '0 ? DRAIN : RUN;
        end
    end
    assert property (@(posedge clk_i) disable iff (!rst_ni) ic_rsp_valid_i |-> !t_empty);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a sequential-stream model
module tb_fetch_queue;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          FQ_DEPTH  = 4;
    localparam int          MAX_OUTST = 2;
    logic        clk_i = 0, rst_ni = 1;
    logic        redir_i = 0, ic_req_ready_i = 0, ic_rsp_valid_i = 0, ic_rsp_err_i = 0, inst_ready_i = 0;
    logic [31:0] redir_pc_i = 0, ic_rsp_data_i = 0;
    logic        ic_req_valid_o, inst_valid_o, inst_err_o;
    logic [31:0] ic_req_addr_o, inst_o, inst_pc_o;
    int          total = 0, bad = 0, cyc = 0, lat_lo = 1, lat_hi = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] pend[$];
    int          due[$];
    logic        fired, popped, pv, p_err;
    logic [31:0] f_addr, p_pc, p_inst, x_pc, x_addr, exp_dec, exp_req;

    fetch_queue #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .redir_i(redir_i), .redir_pc_i(redir_pc_i),
        .ic_req_valid_o(ic_req_valid_o), .ic_req_ready_i(ic_req_ready_i), .ic_req_addr_o(ic_req_addr_o),
        .ic_rsp_valid_i(ic_rsp_valid_i), .ic_rsp_data_i(ic_rsp_data_i), .ic_rsp_err_i(ic_rsp_err_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .inst_err_o(inst_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return a == err_addr;
    endfunction

    // one clock: drive at the negedge, sample 1ns later, model the I-cache and the expected stream
    task automatic cycle(input logic rdy, input logic drdy, input logic rd, input logic [31:0] rpc);
        ic_req_ready_i = rdy;
        inst_ready_i   = drdy;
        redir_i        = rd;
        redir_pc_i     = rpc;
        ic_rsp_valid_i = 0;
        ic_rsp_data_i  = 0;
        ic_rsp_err_i   = 0;
        if (pend.size() > 0 && due[0] <= cyc) begin
            ic_rsp_valid_i = 1;
            ic_rsp_data_i  = mem_of(pend[0]);
            ic_rsp_err_i   = err_of(pend[0]);
        end
        #1;
        fired  = ic_req_valid_o && ic_req_ready_i;
        f_addr = ic_req_addr_o;
        pv     = inst_valid_o;
        popped = inst_valid_o && inst_ready_i;
        p_pc   = inst_pc_o;
        p_inst = inst_o;
        p_err  = inst_err_o;
        if (ic_rsp_valid_i) begin
            void'(pend.pop_front());
            void'(due.pop_front());
        end
        if (fired) begin
            pend.push_back(f_addr);
            due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        end
        x_pc   = exp_dec;
        x_addr = exp_req;
        if (popped) exp_dec += 4;
        if (fired) exp_req += 4;
        if (rd) begin
            exp_dec = {rpc[31:2], 2'b00};
            exp_req = exp_dec;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 0;
        ic_rsp_valid_i = 0;
        pend.delete();
        due.delete();
        repeat (2) @(negedge clk_i);
        exp_dec = RESET_PC;
        exp_req = RESET_PC;
        lat_lo  = 1;
        lat_hi  = 1;
        rst_ni  = 1;
    endtask

    task automatic test_reset();
        ic_req_ready_i = 1;
        inst_ready_i   = 1;
        #1 rst_ni = 0;
        @(negedge clk_i);
        total++; if (ic_req_valid_o !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", ic_req_valid_o); end
        total++; if (ic_req_addr_o !== RESET_PC) begin bad++; $display("FAIL rst_req_addr got=%h exp=%h", ic_req_addr_o, RESET_PC); end
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid_o); end
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", inst_o); end
        total++; if (inst_pc_o !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc_o); end
        total++; if (inst_err_o !== 1'b0) begin bad++; $display("FAIL rst_inst_err got=%b exp=0", inst_err_o); end
        @(negedge clk_i);
        exp_dec = RESET_PC;
        exp_req = RESET_PC;
        rst_ni  = 1;
        cycle(1, 1, 0, 0);
        total++; if (!(fired && f_addr === RESET_PC)) begin bad++; $display("FAIL first_req fired=%b addr=%h exp=%h", fired, f_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        int n_pop = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 0);
            total++; if (!(fired && f_addr === 32'(4 * i))) begin bad++; $display("FAIL stream_req cyc=%0d fired=%b addr=%h exp=%h", i, fired, f_addr, 32'(4 * i)); end
            if (i >= 2) begin
                total++; if (!(popped && p_pc === 32'(4 * (i - 2)) && p_inst === mem_of(p_pc))) begin
                    bad++; $display("FAIL stream_pop cyc=%0d popped=%b pc=%h exp=%h inst=%h", i, popped, p_pc, 32'(4 * (i - 2)), p_inst);
                end
            end
            if (popped) n_pop++;
        end
        total++; if (n_pop != 8) begin bad++; $display("FAIL stream_pop_count got=%0d exp=8", n_pop); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0, 0);
            if (fired) n++;
        end
        total++; if (n != FQ_DEPTH) begin bad++; $display("FAIL bp_req_count got=%0d exp=%0d", n, FQ_DEPTH); end
        total++; if (ic_req_valid_o !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%b exp=0", ic_req_valid_o); end
        cycle(1, 1, 0, 0);
        total++; if (!(popped && p_pc === 32'h0 && !fired)) begin bad++; $display("FAIL bp_pop popped=%b pc=%h fired=%b", popped, p_pc, fired); end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, 0);
            if (fired) begin
                n++;
                total++; if (f_addr !== 32'h10) begin bad++; $display("FAIL bp_refill_addr got=%h exp=00000010", f_addr); end
            end
        end
        total++; if (n != 1) begin bad++; $display("FAIL bp_refill_count got=%0d exp=1", n); end
    endtask

    task automatic test_redirect();
        logic got = 0;
        do_reset();
        lat_lo = 6;
        lat_hi = 6;
        cycle(0, 1, 1, 32'h10);
        cycle(1, 1, 0, 0);
        total++; if (!(fired && f_addr === 32'h10)) begin bad++; $display("FAIL redir_req0 fired=%b addr=%h exp=00000010", fired, f_addr); end
        cycle(1, 1, 0, 0);
        total++; if (!(fired && f_addr === 32'h14)) begin bad++; $display("FAIL redir_req1 fired=%b addr=%h exp=00000014", fired, f_addr); end
        cycle(1, 1, 0, 0);
        total++; if (fired !== 1'b0) begin bad++; $display("FAIL redir_outst_limit fired=%b exp=0", fired); end
        cycle(1, 1, 1, 32'h200);
        for (int i = 0; i < 40 && !got; i++) begin
            cycle(1, 1, 0, 0);
            if (popped) begin
                got = 1;
                total++; if (p_pc !== 32'h200 || p_inst !== mem_of(32'h200)) begin bad++; $display("FAIL redir_first_pc got=%h exp=00000200 inst=%h", p_pc, p_inst); end
            end
        end
        total++; if (!got) begin bad++; $display("FAIL redir_timeout popped=0 exp=1"); end
    endtask

    task automatic test_redirect_same_cycle();
        logic got = 0;
        do_reset();
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 32'h203);
        total++; if (fired !== 1'b0) begin bad++; $display("FAIL same_no_accept fired=%b exp=0", fired); end
        cycle(1, 1, 0, 0);
        total++; if (!(fired && f_addr === 32'h200)) begin bad++; $display("FAIL same_next_addr fired=%b addr=%h exp=00000200", fired, f_addr); end
        total++; if (pv !== 1'b0) begin bad++; $display("FAIL same_q_cleared valid=%b exp=0", pv); end
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(1, 1, 0, 0);
            if (popped) begin
                got = 1;
                total++; if (p_pc !== 32'h200) begin bad++; $display("FAIL same_first_pc got=%h exp=00000200", p_pc); end
            end
        end
        total++; if (!got) begin bad++; $display("FAIL same_timeout popped=0 exp=1"); end
    endtask

    task automatic test_err();
        logic seen8 = 0, seenc = 0;
        do_reset();
        err_addr = 32'h8;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 0, 0);
            if (popped) begin
                total++; if (p_pc !== x_pc || p_inst !== mem_of(x_pc) || p_err !== (x_pc == 32'h8)) begin
                    bad++; $display("FAIL err_entry pc=%h exp=%h inst=%h err=%b", p_pc, x_pc, p_inst, p_err);
                end
                if (p_pc === 32'h8) seen8 = p_err;
                if (p_pc === 32'hC) seenc = !p_err;
            end
        end
        total++; if (!(seen8 && seenc)) begin bad++; $display("FAIL err_seen err8=%b okC=%b exp=1/1", seen8, seenc); end
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_async_reset();
        do_reset();
        lat_lo = 5;
        lat_hi = 5;
        repeat (8) cycle(1, 0, 0, 0);
        total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b exp=1", inst_valid_o); end
        #2 rst_ni = 0;
        #1;
        total++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_pc_o !== 32'h0 || inst_err_o !== 1'b0) begin
            bad++; $display("FAIL arst_outputs valid=%b inst=%h pc=%h err=%b exp=0", inst_valid_o, inst_o, inst_pc_o, inst_err_o);
        end
        total++; if (ic_req_valid_o !== 1'b0 || ic_req_addr_o !== RESET_PC) begin
            bad++; $display("FAIL arst_req valid=%b addr=%h exp=0/%h", ic_req_valid_o, ic_req_addr_o, RESET_PC);
        end
        @(negedge clk_i);
        do_reset();
        cycle(1, 1, 0, 0);
        total++; if (!(fired && f_addr === RESET_PC)) begin bad++; $display("FAIL arst_restart fired=%b addr=%h exp=%h", fired, f_addr, RESET_PC); end
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 0);
            if (popped) begin
                total++; if (p_pc !== x_pc) begin bad++; $display("FAIL arst_stream pc=%h exp=%h", p_pc, x_pc); end
            end
        end
    endtask

    task automatic test_random();
        logic        rd, prev_rd = 0;
        logic [31:0] rpc;
        int          n_pop = 0;
        do_reset();
        lat_lo   = 1;
        lat_hi   = 6;
        err_addr = 32'h20;
        for (int i = 0; i < 3000; i++) begin
            rd  = $urandom_range(15) == 0;
            rpc = $urandom_range(3) == 0 ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : ($urandom & 32'h7F);
            cycle($urandom_range(9) < 7, $urandom_range(9) < 6, rd, rpc);
            if (popped) begin
                n_pop++;
                total++; if (p_pc !== x_pc || p_inst !== mem_of(x_pc) || p_err !== err_of(x_pc)) begin
                    bad++; $display("FAIL rnd_pop cyc=%0d pc=%h exp=%h inst=%h exp=%h err=%b", i, p_pc, x_pc, p_inst, mem_of(x_pc), p_err);
                end
            end
            if (fired) begin
                total++; if (f_addr !== x_addr) begin bad++; $display("FAIL rnd_req cyc=%0d addr=%h exp=%h", i, f_addr, x_addr); end
            end
            if (rd) begin
                total++; if (fired) begin bad++; $display("FAIL rnd_redir_req cyc=%0d fired=1 exp=0", i); end
            end
            if (prev_rd) begin
                total++; if (pv !== 1'b0) begin bad++; $display("FAIL rnd_redir_clear cyc=%0d valid=%b exp=0", i, pv); end
            end
            total++; if (pend.size() > MAX_OUTST) begin bad++; $display("FAIL rnd_outst cyc=%0d got=%0d max=%0d", i, pend.size(), MAX_OUTST); end
            prev_rd = rd;
        end
        total++; if (n_pop < 200) begin bad++; $display("FAIL rnd_progress pops=%0d exp>=200", n_pop); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_err();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
